// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory arbiter slice.
// Round-robin arbitration is selected by defining MEM_ARB_RR_EN.
package mem_arb_pkg;
  localparam int MEM_N = 32;
  localparam int MEM_M = 16;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic {P0 = 1'b0, P1 = 1'b1} port_t;
endpackage

// File: rtl/mem_arb_grant.sv
// Winner selection between the data port (p0) and fetch port (p1).
// With MEM_ARB_RR_EN a last-winner pointer breaks ties; otherwise p0 has fixed priority.
module mem_arb_grant
  import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
  input  logic  clk,
  input  logic  rst,
  input  logic  grant_en,
`endif
  input  logic  p0_req,
  input  logic  p1_req,
  output port_t winner
);

`ifdef MEM_ARB_RR_EN
  port_t last;

  // Reset value P1 as "last winner" makes the first tie go to p0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last <= P1;
    else if (grant_en)
      last <= winner;
  end

  always_comb begin
    winner = P0;
    if (p0_req && p1_req)
      winner = (last == P0) ? P1 : P0;
    else if (p1_req)
      winner = P1;
  end
`else
  assign winner = (p1_req && !p0_req) ? P1 : P0;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port request/acknowledge arbiter in front of the single-port memory.
// Define MEM_ARB_RR_EN for round-robin arbitration (default: p0 fixed priority).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N = MEM_N,
  parameter int M = MEM_M
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         p0_req,
  input  logic         p0_we,
  input  logic [M-1:0] p0_addr,
  input  logic [N-1:0] p0_wdata,
  output logic         p0_ack,
  output logic [N-1:0] p0_rdata,
  input  logic         p1_req,
  input  logic         p1_we,
  input  logic [M-1:0] p1_addr,
  input  logic [N-1:0] p1_wdata,
  output logic         p1_ack,
  output logic [N-1:0] p1_rdata,
  output logic [M-1:0] mem_address,
  output logic         mem_wf,
  output logic [N-1:0] mem_w,
  input  logic [N-1:0] mem_v,
  output logic         busy
);

  state_t       state, state_nxt;
  port_t        winner, owner;
  logic         grant;
  logic         lat_we;
  logic [M-1:0] lat_addr;
  logic [N-1:0] lat_wdata;

  assign grant = (state == IDLE) && (p0_req || p1_req);

  mem_arb_grant u_grant (
`ifdef MEM_ARB_RR_EN
    .clk      (clk),
    .rst      (rst),
    .grant_en (grant),
`endif
    .p0_req   (p0_req),
    .p1_req   (p1_req),
    .winner   (winner)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // The request is snapshotted at grant so later input changes cannot disturb the access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner     <= P0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (grant) begin
      owner     <= winner;
      lat_we    <= (winner == P0) ? p0_we    : p1_we;
      lat_addr  <= (winner == P0) ? p0_addr  : p1_addr;
      lat_wdata <= (winner == P0) ? p0_wdata : p1_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p0_rdata <= '0;
      p1_rdata <= '0;
    end else if (state == ACCESS && !lat_we) begin
      if (owner == P0)
        p0_rdata <= mem_v;
      else
        p1_rdata <= mem_v;
    end
  end

  // Acks and write-enable decode straight from state so an async reset kills them at once.
  always_comb begin
    state_nxt = state;
    p0_ack    = 1'b0;
    p1_ack    = 1'b0;
    mem_wf    = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (grant)
          state_nxt = ACCESS;
      end
      ACCESS: begin
        busy      = 1'b1;
        mem_wf    = lat_we;
        state_nxt = RESP;
      end
      RESP: begin
        busy      = 1'b1;
        p0_ack    = (owner == P0);
        p1_ack    = (owner == P1);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_address = lat_addr;
  assign mem_w       = lat_wdata;

endmodule
